// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// byte width, default timing constants and a modulo index helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } arb_state_e;

   localparam int BYTE_W             = 8;
   localparam int DEF_GAP_CYCLES     = 16;
   localparam int DEF_TIMEOUT_CYCLES = 100000;

   function automatic int wrap_idx(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: the first asserted request at or after
// rr_ptr_i (wrapping) wins.
module rr_picker
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               any_req_o
);

   // Scan from the lowest priority upward so the highest-priority hit is written last.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      any_req_o   = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         grant_idx_o = req_i[wrap_idx(int'(rr_ptr_i), k, NUM_REQ)]
                       ? IDX_W'(wrap_idx(int'(rr_ptr_i), k, NUM_REQ)) : grant_idx_o;
         any_req_o   = any_req_o | req_i[wrap_idx(int'(rr_ptr_i), k, NUM_REQ)];
      end
      grant_o[grant_idx_o] = any_req_o;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ clients: round-robin grant,
// single-cycle launch, completion/watchdog wait and an inter-frame gap.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [BYTE_W*NUM_REQ-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   output logic                        uart_start_o,
   output logic [BYTE_W-1:0]           uart_data_o,
   input  logic                        uart_busy_i,
   input  logic                        uart_done_i,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id_o,
   output logic                        busy_o,
   output logic                        timeout_err_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam arb_state_e AFTER_FRAME    = (GAP_CYCLES > 0) ? GAP : IDLE;

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BYTE_W-1:0]  uart_data_q, uart_data_d;
   logic [IDX_W-1:0]   grant_id_q, grant_id_d;
   logic               uart_start_q, uart_start_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [GAP_W-1:0]   gap_q, gap_d;

   logic [NUM_REQ-1:0] grant_s;
   logic [IDX_W-1:0]   pick_idx_s;
   logic               any_req_s;
   logic [NUM_REQ-1:0] ready_s;
   logic               timeout_s;
   logic [WD_W-1:0]    wd_inc_s;
   logic [GAP_W-1:0]   gap_inc_s;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i       (req_valid_i),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (grant_s),
      .grant_idx_o (pick_idx_s),
      .any_req_o   (any_req_s)
   );

   assign wd_inc_s  = (wd_q == WD_LAST) ? wd_q : wd_q + WD_W'(1);
   assign gap_inc_s = (gap_q == GAP_LAST) ? gap_q : gap_q + GAP_W'(1);

   // Next-state, grant and watchdog/gap counter logic.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      uart_data_d  = uart_data_q;
      grant_id_d   = grant_id_q;
      uart_start_d = 1'b0;
      wd_d         = wd_q;
      gap_d        = '0;
      ready_s      = '0;
      timeout_s    = 1'b0;
      case (state_q)
         IDLE: begin
            wd_d = '0;
            if (any_req_s) begin
               ready_s      = grant_s;
               uart_data_d  = req_data_i[int'(pick_idx_s)*BYTE_W +: BYTE_W];
               grant_id_d   = pick_idx_s;
               rr_ptr_d     = (int'(pick_idx_s) == NUM_REQ - 1) ? '0 : pick_idx_s + IDX_W'(1);
               uart_start_d = ~uart_busy_i;
               state_d      = LAUNCH;
            end else begin
               state_d = IDLE;
            end
         end
         // uart_start_q high marks the launch cycle; until then we hold off on uart_busy.
         LAUNCH: begin
            if (uart_start_q) begin
               wd_d    = '0;
               state_d = WAIT_DONE;
            end else if (!uart_busy_i) begin
               uart_start_d = 1'b1;
               wd_d         = wd_inc_s;
            end else if (wd_q == WD_LAST) begin
               timeout_s = 1'b1;
               state_d   = AFTER_FRAME;
            end else begin
               wd_d = wd_inc_s;
            end
         end
         WAIT_DONE: begin
            if (uart_done_i) begin
               state_d = AFTER_FRAME;
            end else if (wd_q == WD_LAST) begin
               timeout_s = 1'b1;
               state_d   = AFTER_FRAME;
            end else begin
               wd_d = wd_inc_s;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_inc_s;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         uart_data_q  <= 8'h00;
         grant_id_q   <= '0;
         uart_start_q <= 1'b0;
         wd_q         <= '0;
         gap_q        <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         uart_data_q  <= uart_data_d;
         grant_id_q   <= grant_id_d;
         uart_start_q <= uart_start_d;
         wd_q         <= wd_d;
         gap_q        <= gap_d;
      end
   end

   // No byte is accepted during the reset cycle, since it would be dropped.
   assign req_ready_o   = rst ? '0 : ready_s;
   assign timeout_err_o = rst ? 1'b0 : timeout_s;
   assign uart_start_o  = uart_start_q;
   assign uart_data_o   = uart_data_q;
   assign grant_id_o    = grant_id_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter with a transaction-level
// round-robin/timing reference model.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int G = 5;
   localparam int T = 50;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_valid;
   logic [7:0] cdata [4];
   logic [31:0] req_data;
   logic       uart_busy;
   logic       uart_done;
   logic [3:0] req_ready;
   logic       uart_start;
   logic [7:0] uart_data;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout_err;

   int n_pass  = 0;
   int n_total = 0;
   int mptr    = 0;
   bit hold    = 1'b0;

   assign req_data = {cdata[3], cdata[2], cdata[1], cdata[0]};

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ        (N),
      .GAP_CYCLES     (G),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .uart_start_o  (uart_start),
      .uart_data_o   (uart_data),
      .uart_busy_i   (uart_busy),
      .uart_done_i   (uart_done),
      .grant_id_o    (grant_id),
      .busy_o        (busy),
      .timeout_err_o (timeout_err)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Round-robin rule: first valid client at or after the pointer, wrapping.
   function automatic int model_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // One frame from the grant cycle (IDLE with a request) to the first IDLE cycle after the gap.
   // mode 0: uart_done arrives dly cycles after uart_start; mode 1: no done, watchdog expires.
   task automatic do_frame(input int w, input logic [7:0] b, input int mode, input int dly);
      #1;
      check("idle_before_grant", busy, 0);
      check("ready_onehot", req_ready, 32'd1 << w);
      step();
      check("start_latency", uart_start, 1);
      check("uart_data", uart_data, b);
      check("grant_id", grant_id, w);
      check("ready_single_cycle", req_ready, 0);
      mptr = (w + 1) % N;
      if (!hold) req_valid[w] = 1'b0;
      step();
      check("start_single_cycle", uart_start, 0);
      if (mode == 0) begin
         repeat (dly - 1) step();
         uart_done = 1'b1;
         #1;
         check("no_timeout_on_done", timeout_err, 0);
         step();
         uart_done = 1'b0;
      end else begin
         repeat (T - 2) step();
         check("timeout_not_early", timeout_err, 0);
         step();
         check("timeout_pulse", timeout_err, 1);
         step();
         check("timeout_single_cycle", timeout_err, 0);
      end
      for (int g = 0; g < G; g++) begin
         check("gap_busy", busy, 1);
         check("gap_no_ready", req_ready, 0);
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: observed no finish expected finish");
      $fatal(1, "bench time limit expired");
   end

   initial begin
      int         w;
      logic [3:0] m;
      int         fair_exp [6] = '{0, 1, 2, 3, 0, 1};

      rst = 1'b1; req_valid = 4'b0; uart_busy = 1'b0; uart_done = 1'b0;
      for (int c = 0; c < N; c++) cdata[c] = 8'h00;
      repeat (3) step();
      check("rst_ready", req_ready, 0);
      check("rst_start", uart_start, 0);
      check("rst_data", uart_data, 8'h00);
      check("rst_gid", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout_err, 0);
      rst = 1'b0;
      step();
      check("idle_no_req_busy", busy, 0);
      check("idle_no_req_ready", req_ready, 0);

      // Single request from client 2, held so the gap length is visible.
      req_valid = 4'b0100; cdata[2] = 8'hA5; hold = 1'b1;
      do_frame(2, 8'hA5, 0, 10);
      hold = 1'b0;
      do_frame(2, 8'hA5, 0, 10);

      // uart_done outside WAIT_DONE is ignored.
      uart_done = 1'b1;
      #1;
      check("stray_done_busy", busy, 0);
      step();
      uart_done = 1'b0;
      check("stray_done_busy2", busy, 0);
      check("stray_done_start", uart_start, 0);

      // Fairness after reset.
      rst = 1'b1;
      step();
      rst = 1'b0; mptr = 0;
      req_valid = 4'b1111;
      cdata[0] = 8'h10; cdata[1] = 8'h21; cdata[2] = 8'h32; cdata[3] = 8'h43;
      hold = 1'b1;
      for (int i = 0; i < 6; i++) do_frame(fair_exp[i], cdata[fair_exp[i]], 0, 20);
      hold = 1'b0;
      req_valid = 4'b0;

      // Watchdog: client 3 is next in turn, then client 0 follows.
      req_valid = 4'b1001; cdata[3] = 8'hC3; cdata[0] = 8'h0F;
      do_frame(3, 8'hC3, 1, 0);
      do_frame(0, 8'h0F, 0, 8);

      // uart_done on the cycle the watchdog reaches its last count.
      req_valid = 4'b0010; cdata[1] = 8'h5A;
      do_frame(1, 8'h5A, 0, T);

      // Busy hold-off.
      uart_busy = 1'b1; req_valid = 4'b0100; cdata[2] = 8'h3C;
      #1;
      check("busy_ready", req_ready, 4'b0100);
      step();
      req_valid = 4'b0; mptr = 3;
      check("busy_gid", grant_id, 2);
      for (int i = 0; i < 4; i++) begin
         check("busy_no_start", uart_start, 0);
         check("busy_data_held", uart_data, 8'h3C);
         step();
      end
      uart_busy = 1'b0;
      step();
      check("busy_release_start", uart_start, 1);
      check("busy_release_data", uart_data, 8'h3C);
      step();
      check("busy_start_single", uart_start, 0);
      repeat (3) step();
      uart_done = 1'b1;
      step();
      uart_done = 1'b0;
      repeat (G) step();
      check("busy_back_idle", busy, 0);

      // Reset in WAIT_DONE with client 1 next in turn.
      req_valid = 4'b0001; cdata[0] = 8'h11;
      #1;
      check("pre_rst_ready", req_ready, 4'b0001);
      step();
      check("pre_rst_start", uart_start, 1);
      req_valid = 4'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("midrst_ready", req_ready, 0);
      check("midrst_start", uart_start, 0);
      check("midrst_data", uart_data, 8'h00);
      check("midrst_gid", grant_id, 0);
      check("midrst_busy", busy, 0);
      check("midrst_timeout", timeout_err, 0);
      mptr = 0;
      req_valid = 4'b0011; cdata[1] = 8'h22;
      do_frame(0, 8'h11, 0, 6);
      do_frame(1, 8'h22, 0, 6);

      // Randomized frames against the reference model.
      for (int f = 0; f < 12; f++) begin
         m = 4'($urandom_range(1, 15));
         for (int c = 0; c < N; c++) begin
            if (m[c] && !req_valid[c]) begin
               req_valid[c] = 1'b1;
               cdata[c] = 8'($urandom);
            end else if (!m[c] && ($urandom_range(0, 3) == 0)) begin
               req_valid[c] = 1'b0;
            end
         end
         if (req_valid == 4'b0) req_valid[f % N] = 1'b1;
         w = model_pick(req_valid, mptr);
         do_frame(w, cdata[w], 0, $urandom_range(2, T - 1));
         if (f % 4 == 3) begin
            req_valid = 4'b0; uart_done = 1'b1;
            #1;
            check("rand_idle_ready", req_ready, 0);
            step();
            uart_done = 1'b0;
            check("rand_idle_busy", busy, 0);
            check("rand_idle_start", uart_start, 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
